// File: rtl/dlx_pkg.sv
// Shared definitions for the multicycle DLX core: opcodes, instruction
// field positions, the phase encoding and the immediate-extension helper.
package dlx_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_SUBI = 6'b010010;
    localparam logic [5:0] OP_ORI  = 6'b010101;
    localparam logic [5:0] OP_SLLI = 6'b010111;
    localparam logic [5:0] OP_SRAI = 6'b011001;
    localparam logic [5:0] OP_LW   = 6'b000101;
    localparam logic [5:0] OP_SW   = 6'b001010;
    localparam logic [5:0] OP_BEQZ = 6'b100000;
    localparam logic [5:0] OP_JALR = 6'b100011;
    localparam logic [5:0] OP_SEQ  = 6'b110000;

    // Field positions. RT is rd for I-type and rs2 for R-type.
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS1_MSB = 25;
    localparam int RS1_LSB = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [2:0] {
        PH_IF  = 3'd0,
        PH_ID  = 3'd1,
        PH_EX  = 3'd2,
        PH_MEM = 3'd3,
        PH_WB  = 3'd4
    } phase_t;

    // Arithmetic, memory and branch immediates are signed; logic and
    // shift immediates are zero-extended.
    function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm16);
        case (op)
            OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQZ: return {{16{imm16[15]}}, imm16};
            default:                                 return {16'h0000, imm16};
        endcase
    endfunction

endpackage

// File: rtl/dlx_regfile.sv
// 32 x 32-bit general purpose register file.
// Ports:
//   clock, reset          - clock, async active-low clear of all registers
//   rs1_addr/rs1_data     - asynchronous read port 1
//   rs2_addr/rs2_data     - asynchronous read port 2
//   we, wr_addr, wr_data  - synchronous write port (R0 writes dropped)
//   dbg_regs              - all registers flattened, R0 in bits [31:0]
module dlx_regfile
    import dlx_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    output logic [31:0]   rs1_data,
    output logic [31:0]   rs2_data,
    input  logic          we,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    output logic [1023:0] dbg_regs
);

    logic [31:0] rf [32];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (we && (wr_addr != 5'd0)) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : rf[rs2_addr];

    always_comb begin
        dbg_regs = '0;
        for (int i = 0; i < 32; i++) begin
            dbg_regs[32*i +: 32] = rf[i];
        end
    end

endmodule

// File: rtl/dlx_multicycle_core.sv
// Multicycle DLX integer core: one instruction every five clocks through
// IF/ID/EX/MEM/WB phases, so no forwarding or hazard logic exists.
// Ports:
//   clock, reset        - rising-edge clock, async active-low reset
//   pc, inst_in         - fetch address / instruction from registered ROM
//   mem_addr, mem_en    - data address and write strobe (one MEM cycle)
//   memdata_out/in      - store data / combinational load data
//   regs0..regs31       - live GPR contents
//   branch_en, jump_en, alu_branch, alu_out34, imm - EX/ID debug registers
//   fetchclock          - high during the IF phase
//   reg_add, reg_data, reg_write_en - writeback port
//
// phase  | meaning
// PH_IF  | pc stable, ROM fetching, fetchclock high
// PH_ID  | latch instruction fields, operands and immediate
// PH_EX  | ALU result, branch/jump decision and target registered
// PH_MEM | store strobe or load data capture, writeback prepared
// PH_WB  | register write, pc advanced at end of phase
module dlx_multicycle_core
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned PC_STEP  = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic [31:0] memdata_in,
    output logic [31:0] pc,
    output logic [31:0] memdata_out,
    output logic [31:0] mem_addr,
    output logic        mem_en,
    output logic [31:0] regs0,  output logic [31:0] regs1,
    output logic [31:0] regs2,  output logic [31:0] regs3,
    output logic [31:0] regs4,  output logic [31:0] regs5,
    output logic [31:0] regs6,  output logic [31:0] regs7,
    output logic [31:0] regs8,  output logic [31:0] regs9,
    output logic [31:0] regs10, output logic [31:0] regs11,
    output logic [31:0] regs12, output logic [31:0] regs13,
    output logic [31:0] regs14, output logic [31:0] regs15,
    output logic [31:0] regs16, output logic [31:0] regs17,
    output logic [31:0] regs18, output logic [31:0] regs19,
    output logic [31:0] regs20, output logic [31:0] regs21,
    output logic [31:0] regs22, output logic [31:0] regs23,
    output logic [31:0] regs24, output logic [31:0] regs25,
    output logic [31:0] regs26, output logic [31:0] regs27,
    output logic [31:0] regs28, output logic [31:0] regs29,
    output logic [31:0] regs30, output logic [31:0] regs31,
    output logic        branch_en,
    output logic [31:0] alu_branch,
    output logic [31:0] alu_out34,
    output logic        jump_en,
    output logic        fetchclock,
    output logic [4:0]  reg_add,
    output logic [31:0] reg_data,
    output logic        reg_write_en,
    output logic [31:0] imm
);

    localparam logic [31:0] STEP     = 32'(PC_STEP);
    localparam logic [31:0] LINK_OFS = 32'(2 * PC_STEP);

    phase_t        phase;
    logic          running;     // first edge after reset release only arms the core
    logic [5:0]    op_r;        // instruction register fields; all-zero decodes as NOP
    logic [4:0]    rt_r;
    logic [4:0]    rd_r;
    logic [31:0]   a_r;
    logic [31:0]   b_r;

    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic [1023:0] dbg_regs;

    logic [31:0]   alu_res;
    logic [31:0]   target;
    logic          wb_en;
    logic [4:0]    wb_dst;
    logic [31:0]   wb_val;

    dlx_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .rs1_addr (inst_in[RS1_MSB:RS1_LSB]),
        .rs2_addr (inst_in[RT_MSB:RT_LSB]),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (reg_write_en),
        .wr_addr  (reg_add),
        .wr_data  (reg_data),
        .dbg_regs (dbg_regs)
    );

    always_comb begin
        alu_res = '0;
        case (op_r)
            OP_ADDI, OP_LW, OP_SW: alu_res = a_r + imm;
            OP_SUBI:               alu_res = a_r - imm;
            OP_ORI:                alu_res = a_r | imm;
            OP_SLLI:               alu_res = a_r << imm[4:0];
            OP_SRAI:               alu_res = $unsigned($signed(a_r) >>> imm[4:0]);
            OP_SEQ:                alu_res = {31'b0, (a_r == b_r)};
            default:               alu_res = '0;
        endcase
    end

    assign target = (op_r == OP_JALR) ? a_r : (pc + STEP + imm);

    always_comb begin
        wb_en  = 1'b0;
        wb_dst = rt_r;
        wb_val = alu_out34;
        case (op_r)
            OP_ADDI, OP_SUBI, OP_ORI, OP_SLLI, OP_SRAI: wb_en = 1'b1;
            OP_LW: begin
                wb_en  = 1'b1;
                wb_val = memdata_in;
            end
            OP_SEQ: begin
                wb_en  = 1'b1;
                wb_dst = rd_r;
            end
            OP_JALR: begin
                wb_en  = 1'b1;
                wb_dst = LINK_REG;
                wb_val = pc + LINK_OFS;
            end
            default: wb_en = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase        <= PH_IF;
            running      <= 1'b0;
            fetchclock   <= 1'b0;
            pc           <= RESET_PC;
            op_r         <= OP_NOP;
            rt_r         <= '0;
            rd_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            imm          <= '0;
            alu_out34    <= '0;
            alu_branch   <= '0;
            branch_en    <= 1'b0;
            jump_en      <= 1'b0;
            mem_en       <= 1'b0;
            memdata_out  <= '0;
            reg_write_en <= 1'b0;
            reg_add      <= '0;
            reg_data     <= '0;
        end else if (!running) begin
            running    <= 1'b1;
            fetchclock <= 1'b1;
        end else begin
            case (phase)
                PH_IF: begin
                    fetchclock <= 1'b0;
                    phase      <= PH_ID;
                end
                PH_ID: begin
                    op_r  <= inst_in[OP_MSB:OP_LSB];
                    rt_r  <= inst_in[RT_MSB:RT_LSB];
                    rd_r  <= inst_in[RD_MSB:RD_LSB];
                    a_r   <= rs1_data;
                    b_r   <= rs2_data;
                    imm   <= ext_imm(inst_in[OP_MSB:OP_LSB], inst_in[IMM_MSB:0]);
                    phase <= PH_EX;
                end
                PH_EX: begin
                    alu_out34  <= alu_res;
                    alu_branch <= target;
                    branch_en  <= (op_r == OP_BEQZ) && (a_r == 32'd0);
                    jump_en    <= (op_r == OP_JALR);
                    mem_en     <= (op_r == OP_SW);
                    if (op_r == OP_SW) begin
                        memdata_out <= b_r;
                    end
                    phase <= PH_MEM;
                end
                PH_MEM: begin
                    mem_en       <= 1'b0;
                    reg_write_en <= wb_en;
                    reg_add      <= wb_dst;
                    reg_data     <= wb_val;
                    phase        <= PH_WB;
                end
                PH_WB: begin
                    reg_write_en <= 1'b0;
                    pc           <= (branch_en || jump_en) ? alu_branch : (pc + STEP);
                    fetchclock   <= 1'b1;
                    phase        <= PH_IF;
                end
                default: phase <= PH_IF;
            endcase
        end
    end

    assign mem_addr = alu_out34;

    assign regs0  = dbg_regs[0*32  +: 32];
    assign regs1  = dbg_regs[1*32  +: 32];
    assign regs2  = dbg_regs[2*32  +: 32];
    assign regs3  = dbg_regs[3*32  +: 32];
    assign regs4  = dbg_regs[4*32  +: 32];
    assign regs5  = dbg_regs[5*32  +: 32];
    assign regs6  = dbg_regs[6*32  +: 32];
    assign regs7  = dbg_regs[7*32  +: 32];
    assign regs8  = dbg_regs[8*32  +: 32];
    assign regs9  = dbg_regs[9*32  +: 32];
    assign regs10 = dbg_regs[10*32 +: 32];
    assign regs11 = dbg_regs[11*32 +: 32];
    assign regs12 = dbg_regs[12*32 +: 32];
    assign regs13 = dbg_regs[13*32 +: 32];
    assign regs14 = dbg_regs[14*32 +: 32];
    assign regs15 = dbg_regs[15*32 +: 32];
    assign regs16 = dbg_regs[16*32 +: 32];
    assign regs17 = dbg_regs[17*32 +: 32];
    assign regs18 = dbg_regs[18*32 +: 32];
    assign regs19 = dbg_regs[19*32 +: 32];
    assign regs20 = dbg_regs[20*32 +: 32];
    assign regs21 = dbg_regs[21*32 +: 32];
    assign regs22 = dbg_regs[22*32 +: 32];
    assign regs23 = dbg_regs[23*32 +: 32];
    assign regs24 = dbg_regs[24*32 +: 32];
    assign regs25 = dbg_regs[25*32 +: 32];
    assign regs26 = dbg_regs[26*32 +: 32];
    assign regs27 = dbg_regs[27*32 +: 32];
    assign regs28 = dbg_regs[28*32 +: 32];
    assign regs29 = dbg_regs[29*32 +: 32];
    assign regs30 = dbg_regs[30*32 +: 32];
    assign regs31 = dbg_regs[31*32 +: 32];

endmodule

// File: tb/tb_dlx_multicycle_core.sv
// Directed bench for the multicycle DLX core with a registered ROM model
// and a combinational-read RAM model.
module tb_dlx_multicycle_core;

    localparam logic [5:0] ADDI = 6'b010000;
    localparam logic [5:0] SUBI = 6'b010010;
    localparam logic [5:0] ORI  = 6'b010101;
    localparam logic [5:0] SLLI = 6'b010111;
    localparam logic [5:0] SRAI = 6'b011001;
    localparam logic [5:0] LW   = 6'b000101;
    localparam logic [5:0] SW   = 6'b001010;
    localparam logic [5:0] BEQZ = 6'b100000;
    localparam logic [5:0] JALR = 6'b100011;
    localparam logic [5:0] SEQ  = 6'b110000;

    logic        clock;
    logic        reset;
    logic [31:0] inst_in;
    logic [31:0] memdata_in;
    logic [31:0] pc;
    logic [31:0] memdata_out;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic [31:0] regs_w [32];
    logic        branch_en;
    logic [31:0] alu_branch;
    logic [31:0] alu_out34;
    logic        jump_en;
    logic        fetchclock;
    logic [4:0]  reg_add;
    logic [31:0] reg_data;
    logic        reg_write_en;
    logic [31:0] imm;

    logic [31:0] rom [64];
    logic [31:0] ram [64] = '{default: 32'h0};

    int n_checks = 0;
    int n_pass   = 0;

    // monitor state
    int          ph_est       = 7;
    int          mem_en_cnt   = 0;
    int          rwe_cnt      = 0;
    int          bad_mem_ph   = 0;
    int          bad_rwe_ph   = 0;
    logic [31:0] last_maddr   = '0;
    logic [31:0] last_mdata   = '0;

    dlx_multicycle_core dut (
        .clock(clock), .reset(reset), .inst_in(inst_in), .memdata_in(memdata_in),
        .pc(pc), .memdata_out(memdata_out), .mem_addr(mem_addr), .mem_en(mem_en),
        .regs0(regs_w[0]),   .regs1(regs_w[1]),   .regs2(regs_w[2]),   .regs3(regs_w[3]),
        .regs4(regs_w[4]),   .regs5(regs_w[5]),   .regs6(regs_w[6]),   .regs7(regs_w[7]),
        .regs8(regs_w[8]),   .regs9(regs_w[9]),   .regs10(regs_w[10]), .regs11(regs_w[11]),
        .regs12(regs_w[12]), .regs13(regs_w[13]), .regs14(regs_w[14]), .regs15(regs_w[15]),
        .regs16(regs_w[16]), .regs17(regs_w[17]), .regs18(regs_w[18]), .regs19(regs_w[19]),
        .regs20(regs_w[20]), .regs21(regs_w[21]), .regs22(regs_w[22]), .regs23(regs_w[23]),
        .regs24(regs_w[24]), .regs25(regs_w[25]), .regs26(regs_w[26]), .regs27(regs_w[27]),
        .regs28(regs_w[28]), .regs29(regs_w[29]), .regs30(regs_w[30]), .regs31(regs_w[31]),
        .branch_en(branch_en), .alu_branch(alu_branch), .alu_out34(alu_out34),
        .jump_en(jump_en), .fetchclock(fetchclock), .reg_add(reg_add),
        .reg_data(reg_data), .reg_write_en(reg_write_en), .imm(imm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) inst_in <= rom[pc[7:2]];
    always @(posedge clock) if (mem_en) ram[mem_addr[7:2]] <= memdata_out;
    assign memdata_in = ram[mem_addr[7:2]];

    // Tracks cycles since the last fetch strobe; stores belong in slot 3, writebacks in slot 4.
    always @(negedge clock) begin
        if (fetchclock) ph_est = 0;
        else if (ph_est < 7) ph_est = ph_est + 1;
        if (mem_en) begin
            mem_en_cnt = mem_en_cnt + 1;
            last_maddr = mem_addr;
            last_mdata = memdata_out;
            if (ph_est != 3) bad_mem_ph = bad_mem_ph + 1;
        end
        if (reg_write_en) begin
            rwe_cnt = rwe_cnt + 1;
            if (ph_est != 4) bad_rwe_ph = bad_rwe_ph + 1;
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [15:0] im);
        return {op, rs1, rd, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [4:0] rd);
        return {op, rs1, rs2, rd, 11'b0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    endtask

    // Hold reset for two clocks, then release; the caller then waits 1+5*N clocks for N instructions.
    task automatic restart();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int bad_regs;
        int last;
        int n;
        clear_rom();
        reset = 1'b0;
        step(2);
        bad_regs = 0;
        for (int i = 0; i < 32; i++) if (regs_w[i] !== 32'h0) bad_regs++;
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
        n_checks++; if (bad_regs !== 0) $display("FAIL reset_regs nonzero=%0d exp=0", bad_regs); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got=%b exp=0", mem_en); else n_pass++;
        n_checks++; if (fetchclock !== 1'b0) $display("FAIL reset_fetchclock got=%b exp=0", fetchclock); else n_pass++;
        n_checks++; if (reg_write_en !== 1'b0) $display("FAIL reset_rwe got=%b exp=0", reg_write_en); else n_pass++;
        reset = 1'b1;
        last = -1;
        n = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (fetchclock === 1'b1) begin
                n_checks++;
                if (pc !== 32'(n * 4)) $display("FAIL fetch_pc idx=%0d got=%h exp=%h", n, pc, 32'(n * 4));
                else n_pass++;
                if (last >= 0) begin
                    n_checks++;
                    if (i - last != 5) $display("FAIL fetch_gap got=%0d exp=5", i - last); else n_pass++;
                end
                last = i;
                n++;
            end
        end
        n_checks++; if (n != 4) $display("FAIL fetch_pulses got=%0d exp=4", n); else n_pass++;
    endtask

    task automatic test_addi_chain();
        int rwe0, bad0;
        clear_rom();
        rom[0] = itype(ADDI, 5'd1, 5'd2, 16'd15);
        rom[1] = itype(ADDI, 5'd2, 5'd3, 16'd15);
        restart();
        rwe0 = rwe_cnt; bad0 = bad_rwe_ph;
        step(1 + 5 * 2);
        n_checks++; if (regs_w[2] !== 32'd15) $display("FAIL addi_r2 got=%h exp=%h", regs_w[2], 32'd15); else n_pass++;
        n_checks++; if (regs_w[3] !== 32'd30) $display("FAIL addi_r3 got=%h exp=%h", regs_w[3], 32'd30); else n_pass++;
        n_checks++; if (rwe_cnt - rwe0 != 2) $display("FAIL addi_rwe_pulses got=%0d exp=2", rwe_cnt - rwe0); else n_pass++;
        n_checks++; if (bad_rwe_ph - bad0 != 0) $display("FAIL addi_rwe_phase got=%0d exp=0", bad_rwe_ph - bad0); else n_pass++;
    endtask

    task automatic test_store_load();
        int me0, bad0;
        clear_rom();
        rom[0] = itype(ADDI, 5'd0, 5'd2, 16'd15);
        rom[1] = itype(SW,   5'd8, 5'd2, 16'd8);
        rom[2] = itype(LW,   5'd8, 5'd4, 16'd8);
        rom[3] = itype(ADDI, 5'd4, 5'd5, 16'd14);
        restart();
        me0 = mem_en_cnt; bad0 = bad_mem_ph;
        step(1 + 5 * 4);
        n_checks++; if (mem_en_cnt - me0 != 1) $display("FAIL sw_mem_en_cycles got=%0d exp=1", mem_en_cnt - me0); else n_pass++;
        n_checks++; if (last_maddr !== 32'd8) $display("FAIL sw_addr got=%h exp=%h", last_maddr, 32'd8); else n_pass++;
        n_checks++; if (last_mdata !== 32'd15) $display("FAIL sw_data got=%h exp=%h", last_mdata, 32'd15); else n_pass++;
        n_checks++; if (bad_mem_ph - bad0 != 0) $display("FAIL sw_phase got=%0d exp=0", bad_mem_ph - bad0); else n_pass++;
        n_checks++; if (regs_w[4] !== 32'd15) $display("FAIL lw_r4 got=%h exp=%h", regs_w[4], 32'd15); else n_pass++;
        n_checks++; if (regs_w[5] !== 32'd29) $display("FAIL lw_use_r5 got=%h exp=%h", regs_w[5], 32'd29); else n_pass++;
    endtask

    task automatic test_logic_shift();
        clear_rom();
        rom[0] = itype(ORI,  5'd5, 5'd6,  16'h8460);
        rom[1] = itype(ADDI, 5'd0, 5'd2,  16'd15);
        rom[2] = itype(SLLI, 5'd2, 5'd12, 16'd5);
        rom[3] = itype(ADDI, 5'd0, 5'd4,  16'hFF00);
        rom[4] = itype(SRAI, 5'd4, 5'd28, 16'd5);
        rom[5] = itype(ADDI, 5'd0, 5'd7,  16'd5);
        rom[6] = rtype(SEQ,  5'd2, 5'd12, 5'd7);
        rom[7] = itype(ADDI, 5'd0, 5'd3,  16'd15);
        rom[8] = rtype(SEQ,  5'd2, 5'd3,  5'd8);
        rom[9] = itype(SUBI, 5'd2, 5'd9,  16'd20);
        restart();
        step(1 + 5 * 10);
        n_checks++; if (regs_w[6]  !== 32'h00008460) $display("FAIL ori_r6 got=%h exp=%h", regs_w[6], 32'h00008460); else n_pass++;
        n_checks++; if (regs_w[12] !== 32'd480) $display("FAIL slli_r12 got=%h exp=%h", regs_w[12], 32'd480); else n_pass++;
        n_checks++; if (regs_w[4]  !== 32'hFFFFFF00) $display("FAIL addi_sext_r4 got=%h exp=%h", regs_w[4], 32'hFFFFFF00); else n_pass++;
        n_checks++; if (regs_w[28] !== 32'hFFFFFFF8) $display("FAIL srai_r28 got=%h exp=%h", regs_w[28], 32'hFFFFFFF8); else n_pass++;
        n_checks++; if (regs_w[7]  !== 32'd0) $display("FAIL seq_ne_r7 got=%h exp=%h", regs_w[7], 32'd0); else n_pass++;
        n_checks++; if (regs_w[8]  !== 32'd1) $display("FAIL seq_eq_r8 got=%h exp=%h", regs_w[8], 32'd1); else n_pass++;
        n_checks++; if (regs_w[9]  !== 32'hFFFFFFFB) $display("FAIL subi_r9 got=%h exp=%h", regs_w[9], 32'hFFFFFFFB); else n_pass++;
    endtask

    task automatic test_branch_jump();
        clear_rom();
        rom[4] = itype(BEQZ, 5'd10, 5'd0, 16'd14);
        restart();
        step(1 + 5 * 5);
        n_checks++; if (branch_en !== 1'b1) $display("FAIL beqz_taken_en got=%b exp=1", branch_en); else n_pass++;
        n_checks++; if (alu_branch !== 32'h22) $display("FAIL beqz_target got=%h exp=%h", alu_branch, 32'h22); else n_pass++;
        n_checks++; if (pc !== 32'h22) $display("FAIL beqz_taken_pc got=%h exp=%h", pc, 32'h22); else n_pass++;
        n_checks++; if (imm !== 32'd14) $display("FAIL beqz_imm got=%h exp=%h", imm, 32'd14); else n_pass++;

        rom[0] = itype(ADDI, 5'd0, 5'd10, 16'd1);
        restart();
        step(1 + 5 * 5);
        n_checks++; if (branch_en !== 1'b0) $display("FAIL beqz_nt_en got=%b exp=0", branch_en); else n_pass++;
        n_checks++; if (pc !== 32'h14) $display("FAIL beqz_nt_pc got=%h exp=%h", pc, 32'h14); else n_pass++;
        n_checks++; if (alu_branch !== 32'h22) $display("FAIL beqz_nt_target got=%h exp=%h", alu_branch, 32'h22); else n_pass++;

        clear_rom();
        rom[0] = itype(ADDI, 5'd0, 5'd11, 16'h40);
        rom[8] = rtype(JALR, 5'd11, 5'd0, 5'd0);
        restart();
        step(1 + 5 * 9);
        n_checks++; if (jump_en !== 1'b1) $display("FAIL jalr_en got=%b exp=1", jump_en); else n_pass++;
        n_checks++; if (regs_w[31] !== 32'h28) $display("FAIL jalr_link got=%h exp=%h", regs_w[31], 32'h28); else n_pass++;
        n_checks++; if (pc !== 32'h40) $display("FAIL jalr_pc got=%h exp=%h", pc, 32'h40); else n_pass++;
    endtask

    task automatic test_r0_write();
        int rwe0;
        clear_rom();
        rom[0] = itype(ADDI, 5'd0, 5'd0, 16'd7);
        restart();
        rwe0 = rwe_cnt;
        step(1 + 5 * 1);
        n_checks++; if (regs_w[0] !== 32'h0) $display("FAIL r0_stays_zero got=%h exp=%h", regs_w[0], 32'h0); else n_pass++;
        n_checks++; if (rwe_cnt - rwe0 != 1) $display("FAIL r0_rwe_pulse got=%0d exp=1", rwe_cnt - rwe0); else n_pass++;
        n_checks++; if (reg_data !== 32'd7) $display("FAIL r0_reg_data got=%h exp=%h", reg_data, 32'd7); else n_pass++;
    endtask

    task automatic test_reset_mid_sw();
        int me0;
        clear_rom();
        rom[0] = itype(ADDI, 5'd0, 5'd2, 16'd15);
        rom[1] = itype(SW,   5'd0, 5'd2, 16'd12);
        restart();
        me0 = mem_en_cnt;
        step(1 + 5 * 1);
        step(2);            // now in the EX phase of the store
        reset = 1'b0;
        step(3);
        n_checks++; if (mem_en_cnt - me0 != 0) $display("FAIL midsw_mem_en got=%0d exp=0", mem_en_cnt - me0); else n_pass++;
        n_checks++; if (ram[3] !== 32'h0) $display("FAIL midsw_ram got=%h exp=%h", ram[3], 32'h0); else n_pass++;
        n_checks++; if (regs_w[2] !== 32'h0) $display("FAIL midsw_regs_cleared got=%h exp=%h", regs_w[2], 32'h0); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL midsw_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_addi_chain();
        test_store_load();
        test_logic_shift();
        test_branch_jump();
        test_r0_write();
        test_reset_mid_sw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
